// File: rtl/change_dispenser_pkg.sv
// Shared types and helpers for the change dispenser: coin denominations,
// FSM state encoding and the rupee value of each denomination.
package change_pkg;

    localparam int DENOM_NUM = 4;

    typedef enum logic [1:0] {
        D_RS1  = 2'd0,
        D_RS2  = 2'd1,
        D_RS5  = 2'd2,
        D_RS10 = 2'd3
    } denom_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_EJECT  = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // Rupee value of one coin of the given denomination.
    function automatic logic [3:0] denom_value(input denom_t d);
        logic [3:0] v;
        case (d)
            D_RS1:   v = 4'd1;
            D_RS2:   v = 4'd2;
            D_RS5:   v = 4'd5;
            default: v = 4'd10;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle of the request, refill, ejector and status signals of the
// change dispenser. master = vend FSM / ejector side, slave = dispenser.
interface change_dispenser_if #(
    parameter int AMT_W = 8,
    parameter int CNT_W = 4
) ();
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;

    logic             refill_valid;
    logic [1:0]       refill_denom;
    logic [CNT_W-1:0] refill_count;

    logic             eject_valid;
    logic [1:0]       eject_denom;
    logic             eject_ack;

    logic             busy;
    logic             done;
    logic             short_change;
    logic [AMT_W-1:0] remaining;

    modport master (
        output req_valid, req_amount, refill_valid, refill_denom, refill_count, eject_ack,
        input  req_ready, eject_valid, eject_denom, busy, done, short_change, remaining
    );

    modport slave (
        input  req_valid, req_amount, refill_valid, refill_denom, refill_count, eject_ack,
        output req_ready, eject_valid, eject_denom, busy, done, short_change, remaining
    );
endinterface

// File: rtl/change_dispenser_inventory.sv
// Coin inventory: one saturating counter per denomination, with a refill
// port (adds coins, clamps at full scale) and a single-coin decrement port.
// The nonzero vector feeds the greedy selection in the dispenser FSM.
module coin_inventory
    import change_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int INIT_COUNT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_refill_en,
    input  logic [1:0]           i_refill_denom,
    input  logic [CNT_W-1:0]     i_refill_count,
    input  logic                 i_dec_en,
    input  logic [1:0]           i_dec_denom,
    output logic [DENOM_NUM-1:0] o_nonzero
);

    for (genvar g = 0; g < DENOM_NUM; g++) begin : g_cnt
        localparam logic [1:0] IDX = 2'(g);

        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W:0]   w_sum;

        assign w_sum        = {1'b0, r_cnt} + {1'b0, i_refill_count};
        assign o_nonzero[g] = (r_cnt != '0);

        // Per-denomination counter: reload on reset, saturating refill, guarded decrement.
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_cnt <= CNT_W'(INIT_COUNT);
            end else if (i_refill_en && (i_refill_denom == IDX)) begin
                r_cnt <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
            end else if (i_dec_en && (i_dec_denom == IDX) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: accepts an amount, pays it out one coin at a time using
// strictly greedy selection over a four-denomination inventory, waits a
// recovery gap after each eject, and reports done / short_change.
module change_dispenser
    import change_pkg::*;
#(
    parameter int AMT_W      = 8,
    parameter int CNT_W      = 4,
    parameter int INIT_COUNT = 8,
    parameter int GAP_CYC    = 4
) (
    input logic          clk,
    input logic          rst,
    change_dispenser_if.slave bus
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t               r_state;
    state_t               w_next;
    logic [AMT_W-1:0]     r_remaining;
    logic                 r_short;
    denom_t               r_eject_denom;
    logic [GAP_W-1:0]     r_gap;

    logic [DENOM_NUM-1:0] w_nonzero;
    logic                 w_found;
    denom_t               w_pick;
    logic                 w_accept;
    logic                 w_handshake;
    logic                 w_refill_en;

    // Requests and refills only land while idle; ack only counts while ejecting.
    assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
    assign w_handshake = (r_state == S_EJECT) && bus.eject_ack;
    assign w_refill_en = (r_state == S_IDLE) && bus.refill_valid;

    coin_inventory #(
        .CNT_W      (CNT_W),
        .INIT_COUNT (INIT_COUNT)
    ) u_inv (
        .clk            (clk),
        .rst            (rst),
        .i_refill_en    (w_refill_en),
        .i_refill_denom (bus.refill_denom),
        .i_refill_count (bus.refill_count),
        .i_dec_en       (w_handshake),
        .i_dec_denom    (r_eject_denom),
        .o_nonzero      (w_nonzero)
    );

    // Greedy pick: largest in-stock denomination that does not exceed the balance.
    always_comb begin
        w_found = 1'b0;
        w_pick  = D_RS1;
        for (int i = DENOM_NUM - 1; i >= 0; i--) begin
            if (!w_found && w_nonzero[i] &&
                (AMT_W'(denom_value(denom_t'(i[1:0]))) <= r_remaining)) begin
                w_found = 1'b1;
                w_pick  = denom_t'(i[1:0]);
            end
        end
    end

    // Next-state logic. A zero balance never finds a coin, so it finishes cleanly.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_next = S_SELECT;
            S_SELECT: w_next = w_found ? S_EJECT : S_FINISH;
            S_EJECT:  if (bus.eject_ack) w_next = S_GAP;
            S_GAP:    if (r_gap == GAP_W'(GAP_CYC - 1)) w_next = S_SELECT;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Balance, short flag, selected coin and gap counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_remaining   <= '0;
            r_short       <= 1'b0;
            r_eject_denom <= D_RS1;
            r_gap         <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) r_remaining <= bus.req_amount;
                end
                S_SELECT: begin
                    if (w_found)                  r_eject_denom <= w_pick;
                    else if (r_remaining != '0)   r_short       <= 1'b1;
                end
                S_EJECT: begin
                    r_gap <= '0;
                    if (bus.eject_ack)
                        r_remaining <= r_remaining - AMT_W'(denom_value(r_eject_denom));
                end
                S_GAP: begin
                    r_gap <= r_gap + 1'b1;
                end
                S_FINISH: begin
                    r_short <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = (r_state == S_IDLE);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.eject_valid  = (r_state == S_EJECT);
    assign bus.eject_denom  = r_eject_denom;
    assign bus.done         = (r_state == S_FINISH);
    assign bus.short_change = (r_state == S_FINISH) && r_short;
    assign bus.remaining    = r_remaining;

endmodule
